instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction register. It owns the program counter and runs a req/ack handshake to instruction memory. Each fetched 16-bit word is presented on ins with a one-cycle IL strobe, so the instruction register latches it on that clock edge. The block honours downstream stall, branch redirect (pc_load) and halt, and flags memory timeouts.

Parameters:
PC_W, 8, program counter / memory address width
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, max cycles in FETCH without mem_ack before error (1..255)

Ports:
clk_main  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_req  output  1  fetch request, registered
mem_addr  output  PC_W  fetch address, equals pc while mem_req=1
mem_ack  input  1  one-cycle acknowledge; mem_rdata valid in same cycle
mem_rdata  input  16  instruction word from memory
ins  output  16  captured instruction, registered
IL  output  1  instruction-load strobe, one cycle per delivered word
stall  input  1  downstream busy, level; blocks next fetch
halt  input  1  level; stop fetching at next instruction boundary
pc_load  input  1  redirect request, one cycle
pc_target  input  PC_W  redirect address
pc  output  PC_W  current program counter
halted  output  1  high in HALTED state
fetch_err  output  1  sticky memory-timeout flag

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, ins=0, IL=0, mem_req=0, halted=0, fetch_err=0, redirect_pending=0, timeout counter=0.
- All outputs are registered. mem_addr = pc.
- States: IDLE, FETCH, ISSUE, HOLD, HALTED.
- IDLE: if halt go to HALTED, else go to FETCH. Lasts one cycle after reset release.
- FETCH: mem_req=1. mem_addr is stable until ack. Timeout counter increments each cycle without ack.
  - On mem_ack with no redirect pending and pc_load=0: ins<=mem_rdata, pc<=pc+1 (wraps mod 2^PC_W), mem_req<=0, IL<=1, go to ISSUE.
  - pc_load during FETCH (before or on the ack cycle): set redirect_pending and latch target. On ack, discard the word (ins unchanged, no IL), pc<=target, clear pending, re-enter FETCH with mem_req dropped for one cycle.
  - Counter reaching TIMEOUT without ack: fetch_err<=1, mem_req<=0, go to HALTED. A late mem_ack arriving outside FETCH is ignored.
- ISSUE: IL=1 for exactly this cycle. ins is held.
  - pc_load: pc<=pc_target. It overrides the earlier increment.
  - Next state: halt -> HALTED; else stall -> HOLD; else FETCH.
- HOLD: IL=0, mem_req=0.
  - pc_load: pc<=pc_target.
  - halt -> HALTED; else when stall=0 -> FETCH.
- HALTED: halted=1, mem_req=0, IL=0.
  - pc_load is accepted.
  - Leave to FETCH only when halt=0 and fetch_err=0. fetch_err is cleared only by reset.
- Zero-wait memory (ack in the first FETCH cycle): FETCH, ISSUE, FETCH, giving 2 cycles per instruction. Each wait cycle adds 1.
- halt during FETCH does not abort the transaction: the word is delivered via ISSUE, then the block enters HALTED.
- Priority within a cycle: reset > timeout > pc_load > increment.
- ins is never modified except on a non-discarded ack.
- Reset mid-FETCH: mem_req drops asynchronously, and no IL follows.

Test Plan:
- Reset then zero-wait memory returning 16'h1234 at 0 and 16'hA5C3 at 1 -> IL pulses 2 cycles apart, ins=1234 then A5C3, pc 0->1->2, mem_addr 0 then 1.
- Memory acks after 3 wait cycles -> mem_req high 4 cycles with mem_addr constant. IL is a single pulse. stall=1 held 5 cycles after ISSUE -> no mem_req until stall falls, then fetch resumes at the next pc.
- pc_load=1, pc_target=8'h40 in the second FETCH cycle of a wait-state fetch -> returned word discarded, no IL, next mem_addr=40, delivered word from 40.
- PC_W=8, pc=8'hFF, fetch acked -> pc wraps to 8'h00.
- No mem_ack for 15 cycles -> fetch_err=1, halted=1, mem_req=0. Deasserting halt does not resume; only reset clears the flag.
- halt asserted mid-FETCH -> pending word still issued with IL=1, then halted=1. halt released -> FETCH resumes. Async reset pulse mid-FETCH -> mem_req=0 immediately and pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and fetches 16-bit instruction words over a req/ack
// handshake, delivering each word on ins with a one-cycle IL strobe.
module instr_fetch_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 15
) (
   input  logic            clk_main,
   input  logic            reset,
   output logic            mem_req,
   output logic [PC_W-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [15:0]     mem_rdata,
   output logic [15:0]     ins,
   output logic            IL,
   input  logic            stall,
   input  logic            halt,
   input  logic            pc_load,
   input  logic [PC_W-1:0] pc_target,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            fetch_err
);
   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, HOLD, HALTED} state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
   logic [15:0]     ins_q, ins_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            il_q, il_d, req_q, req_d, halted_q, halted_d;
   logic            err_q, err_d, redir_q, redir_d, drop;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      tgt_d   = tgt_q;
      il_d    = 1'b0;
      err_d   = err_q;
      redir_d = redir_q;
      cnt_d   = '0;
      drop    = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = halt ? HALTED : FETCH;
            if (pc_load) pc_d = pc_target;
         end
         FETCH: begin
            // req low in FETCH is the one-cycle gap after a discarded word
            if (!req_q) begin
               if (pc_load) pc_d = pc_target;
            end else if (mem_ack) begin
               if (redir_q || pc_load) begin
                  pc_d    = pc_load ? pc_target : tgt_q;
                  redir_d = 1'b0;
                  drop    = 1'b1;
               end else begin
                  ins_d   = mem_rdata;
                  pc_d    = pc_q + PC_W'(1);
                  il_d    = 1'b1;
                  state_d = ISSUE;
               end
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               redir_d = 1'b0;
               state_d = HALTED;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (pc_load) begin
                  redir_d = 1'b1;
                  tgt_d   = pc_target;
               end
            end
         end
         ISSUE, HOLD: begin
            if (pc_load) pc_d = pc_target;
            state_d = halt ? HALTED : stall ? HOLD : FETCH;
         end
         HALTED: begin
            if (pc_load) pc_d = pc_target;
            state_d = (!halt && !err_q) ? FETCH : HALTED;
         end
         default: state_d = IDLE;
      endcase
      req_d    = (state_d == FETCH) && !drop;
      halted_d = (state_d == HALTED);
   end

   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         tgt_q    <= '0;
         ins_q    <= '0;
         cnt_q    <= '0;
         il_q     <= 1'b0;
         req_q    <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
         redir_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         tgt_q    <= tgt_d;
         ins_q    <= ins_d;
         cnt_q    <= cnt_d;
         il_q     <= il_d;
         req_q    <= req_d;
         halted_q <= halted_d;
         err_q    <= err_d;
         redir_q  <= redir_d;
      end
   end

   assign mem_req   = req_q;
   assign mem_addr  = pc_q;
   assign ins       = ins_q;
   assign IL        = il_q;
   assign pc        = pc_q;
   assign halted    = halted_q;
   assign fetch_err = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scenario tasks plus a randomized run checked against a
// program-order model (words delivered in address order from a TB memory).
module tb_instr_fetch_unit;
   logic        clk_main = 1'b0;
   logic        reset = 1'b0;
   logic        mem_req, mem_ack = 1'b0;
   logic [7:0]  mem_addr, pc, pc_target = '0;
   logic [15:0] mem_rdata = '0, ins;
   logic        IL, stall = 1'b0, halt = 1'b0, pc_load = 1'b0, halted, fetch_err;

   instr_fetch_unit #(.PC_W(8), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
      .clk_main(clk_main), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins(ins), .IL(IL), .stall(stall),
      .halt(halt), .pc_load(pc_load), .pc_target(pc_target), .pc(pc),
      .halted(halted), .fetch_err(fetch_err)
   );

   always #5 clk_main = ~clk_main;

   int passed = 0, total = 0;
   logic [15:0] mem [256];
   int wait_cyc = 0, req_run = 0, cyc_n = 0, tot_req = 0;
   bit resp_en = 1, rand_wait = 0, addr_moved = 0;
   logic [7:0] req_addr0;
   logic [15:0] il_ins[$];
   logic [7:0]  il_pc[$], ack_addr[$];
   int          il_cyc[$], req_len[$];

   task automatic tick();
      @(posedge clk_main);
      #1;
   endtask

   // One clock: observe outputs after the edge, then play the memory for the next edge.
   task automatic cyc();
      tick();
      cyc_n++;
      if (IL) begin
         il_ins.push_back(ins);
         il_pc.push_back(pc);
         il_cyc.push_back(cyc_n);
      end
      if (mem_req) tot_req++;
      mem_rdata = 16'($urandom);
      if (resp_en && mem_req) begin
         if (req_run == 0) begin
            req_addr0 = mem_addr;
            if (rand_wait) wait_cyc = $urandom_range(0, 4);
         end else if (mem_addr != req_addr0) addr_moved = 1;
         req_run++;
         if (req_run > wait_cyc) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr];
            ack_addr.push_back(mem_addr);
            req_len.push_back(req_run);
            req_run = 0;
         end else mem_ack = 1'b0;
      end else begin
         mem_ack = 1'b0;
         req_run = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      {mem_ack, stall, halt, pc_load} = '0;
      repeat (2) tick();
      il_ins.delete(); il_pc.delete(); il_cyc.delete(); ack_addr.delete(); req_len.delete();
      req_run = 0; tot_req = 0; addr_moved = 0; cyc_n = 0;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      total++; if (mem_req !== 1'b0) $display("FAIL reset_req got %b want 0", mem_req); else passed++;
      total++; if (IL !== 1'b0) $display("FAIL reset_il got %b want 0", IL); else passed++;
      total++; if (ins !== 16'h0) $display("FAIL reset_ins got %h want 0000", ins); else passed++;
      total++; if (pc !== 8'h00) $display("FAIL reset_pc got %h want 00", pc); else passed++;
      total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else passed++;
      total++; if (fetch_err !== 1'b0) $display("FAIL reset_err got %b want 0", fetch_err); else passed++;
   endtask

   task automatic test_zero_wait();
      mem[0] = 16'h1234; mem[1] = 16'hA5C3;
      wait_cyc = 0; rand_wait = 0; resp_en = 1;
      do_reset();
      for (int i = 0; i < 20 && il_ins.size() < 2; i++) cyc();
      total++;
      if (il_ins.size() < 2) $display("FAIL zw_timeout got %0d IL pulses want 2", il_ins.size());
      else begin
         passed++;
         total++; if (il_ins[0] !== 16'h1234) $display("FAIL zw_ins0 got %h want 1234", il_ins[0]); else passed++;
         total++; if (il_pc[0] !== 8'h01) $display("FAIL zw_pc0 got %h want 01", il_pc[0]); else passed++;
         total++; if (il_ins[1] !== 16'hA5C3) $display("FAIL zw_ins1 got %h want a5c3", il_ins[1]); else passed++;
         total++; if (il_pc[1] !== 8'h02) $display("FAIL zw_pc1 got %h want 02", il_pc[1]); else passed++;
         total++; if (il_cyc[1] - il_cyc[0] !== 2) $display("FAIL zw_spacing got %0d want 2", il_cyc[1] - il_cyc[0]); else passed++;
         total++; if (ack_addr[0] !== 8'h00 || ack_addr[1] !== 8'h01)
            $display("FAIL zw_addr got %h,%h want 00,01", ack_addr[0], ack_addr[1]); else passed++;
      end
   endtask

   task automatic test_wait_stall();
      bit saw_req = 0;
      mem[0] = 16'h0BAD;
      wait_cyc = 3; rand_wait = 0; resp_en = 1;
      do_reset();
      for (int i = 0; i < 20 && il_ins.size() < 1; i++) cyc();
      total++; if (il_ins.size() !== 1) $display("FAIL ws_il got %0d pulses want 1", il_ins.size()); else passed++;
      total++; if (req_len.size() < 1 || req_len[0] !== 4) $display("FAIL ws_req_len got %0d want 4", req_len.size() ? req_len[0] : -1); else passed++;
      total++; if (addr_moved !== 1'b0) $display("FAIL ws_addr_stable got moved=%b want 0", addr_moved); else passed++;
      stall = 1'b1;
      repeat (5) begin cyc(); saw_req |= mem_req; end
      total++; if (saw_req !== 1'b0) $display("FAIL ws_stall_req got %b want 0", saw_req); else passed++;
      total++; if (il_ins.size() !== 1) $display("FAIL ws_single_il got %0d want 1", il_ins.size()); else passed++;
      stall = 1'b0;
      cyc();
      total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01)
         $display("FAIL ws_resume got req=%b addr=%h want 1,01", mem_req, mem_addr); else passed++;
   endtask

   task automatic test_redirect();
      mem[0] = 16'h1111; mem[8'h40] = 16'hBEEF;
      wait_cyc = 3; rand_wait = 0; resp_en = 1;
      do_reset();
      for (int i = 0; i < 5 && !mem_req; i++) cyc();
      cyc();
      pc_load = 1'b1; pc_target = 8'h40;
      cyc();
      pc_load = 1'b0;
      for (int i = 0; i < 30 && il_ins.size() < 1; i++) cyc();
      total++;
      if (il_ins.size() < 1) $display("FAIL rd_timeout got 0 IL pulses want 1");
      else begin
         passed++;
         total++; if (il_ins[0] !== 16'hBEEF) $display("FAIL rd_ins got %h want beef", il_ins[0]); else passed++;
         total++; if (il_pc[0] !== 8'h41) $display("FAIL rd_pc got %h want 41", il_pc[0]); else passed++;
         total++; if (ack_addr.size() !== 2 || ack_addr[1] !== 8'h40)
            $display("FAIL rd_acks got %0d acks want 2 ending at 40", ack_addr.size()); else passed++;
      end
   endtask

   task automatic test_wrap();
      mem[0] = 16'h2222; mem[8'hFF] = 16'h77AA;
      wait_cyc = 0; rand_wait = 0; resp_en = 1;
      do_reset();
      for (int i = 0; i < 10 && il_ins.size() < 1; i++) cyc();
      pc_load = 1'b1; pc_target = 8'hFF;
      cyc();
      pc_load = 1'b0;
      total++; if (mem_addr !== 8'hFF) $display("FAIL wr_addr got %h want ff", mem_addr); else passed++;
      for (int i = 0; i < 10 && il_ins.size() < 2; i++) cyc();
      total++;
      if (il_ins.size() < 2) $display("FAIL wr_timeout got %0d IL pulses want 2", il_ins.size());
      else begin
         passed++;
         total++; if (il_ins[1] !== 16'h77AA) $display("FAIL wr_ins got %h want 77aa", il_ins[1]); else passed++;
         total++; if (il_pc[1] !== 8'h00) $display("FAIL wr_pc got %h want 00", il_pc[1]); else passed++;
      end
   endtask

   task automatic test_timeout();
      resp_en = 0;
      do_reset();
      for (int i = 0; i < 40 && !fetch_err; i++) cyc();
      total++; if (tot_req !== 15) $display("FAIL to_req_cycles got %0d want 15", tot_req); else passed++;
      total++; if (fetch_err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0)
         $display("FAIL to_flags got err=%b halted=%b req=%b want 1,1,0", fetch_err, halted, mem_req); else passed++;
      halt = 1'b0;
      mem_ack = 1'b1;
      repeat (10) cyc();
      total++; if (halted !== 1'b1 || mem_req !== 1'b0 || il_ins.size() !== 0 || tot_req !== 15)
         $display("FAIL to_stuck got halted=%b req=%b il=%0d want 1,0,0", halted, mem_req, il_ins.size()); else passed++;
      reset = 1'b0;
      #1;
      total++; if (fetch_err !== 1'b0) $display("FAIL to_reset_clear got %b want 0", fetch_err); else passed++;
      resp_en = 1;
   endtask

   task automatic test_halt();
      mem[0] = 16'hC0DE;
      wait_cyc = 2; rand_wait = 0; resp_en = 1;
      do_reset();
      for (int i = 0; i < 5 && !mem_req; i++) cyc();
      halt = 1'b1;
      for (int i = 0; i < 10 && il_ins.size() < 1; i++) cyc();
      total++; if (il_ins.size() !== 1 || il_ins[0] !== 16'hC0DE)
         $display("FAIL ht_issue got %0d pulses want 1 with c0de", il_ins.size()); else passed++;
      cyc();
      total++; if (halted !== 1'b1) $display("FAIL ht_halted got %b want 1", halted); else passed++;
      repeat (3) cyc();
      total++; if (mem_req !== 1'b0 || halted !== 1'b1) $display("FAIL ht_idle got req=%b want 0", mem_req); else passed++;
      halt = 1'b0;
      cyc();
      total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || halted !== 1'b0)
         $display("FAIL ht_resume got req=%b addr=%h want 1,01", mem_req, mem_addr); else passed++;
      reset = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0 || pc !== 8'h00 || IL !== 1'b0)
         $display("FAIL ht_async_reset got req=%b pc=%h il=%b want 0,00,0", mem_req, pc, IL); else passed++;
   endtask

   task automatic test_random();
      logic [7:0] exp_addr = 8'h00;
      int n = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      rand_wait = 1; resp_en = 1;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         stall = ($urandom_range(0, 3) == 0);
         cyc();
         while (il_ins.size() > 0) begin
            logic [15:0] gi = il_ins.pop_front();
            logic [7:0] gp = il_pc.pop_front();
            total++; if (gi !== mem[exp_addr]) $display("FAIL rnd_ins got %h want %h at %h", gi, mem[exp_addr], exp_addr); else passed++;
            total++; if (gp !== exp_addr + 8'd1) $display("FAIL rnd_pc got %h want %h", gp, exp_addr + 8'd1); else passed++;
            exp_addr++;
            n++;
         end
      end
      stall = 1'b0;
      total++; if (n < 40 || fetch_err !== 1'b0) $display("FAIL rnd_progress got %0d words err=%b want >=40,0", n, fetch_err); else passed++;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_stall();
      test_redirect();
      test_wrap();
      test_timeout();
      test_halt();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
